// File: rtl/cheshire_pad_mux_pkg.sv
// Shared register map constants and types for the Cheshire pad multiplexer.
// SEL words occupy indices 0..NumPads-1; LOCK and INFO follow directly after.
package cheshire_pad_mux_pkg;

    // Widest select field, covering up to 16 alternate functions per pad.
    localparam int unsigned MaxFuncW = 4;

    // Word offsets of the control registers, relative to NumPads.
    localparam int unsigned LockWordOffset = 0;
    localparam int unsigned InfoWordOffset = 1;

    // INFO register field positions.
    localparam int unsigned InfoNumPadsLsb  = 0;
    localparam int unsigned InfoNumFuncsLsb = 8;

    typedef enum logic [1:0] {
        RegSel,
        RegLock,
        RegInfo,
        RegNone
    } reg_kind_e;

    // Per-pad configuration update delivered from the register file to a slice.
    typedef struct packed {
        logic                we;
        logic [MaxFuncW-1:0] sel;
    } pad_cfg_t;

    function automatic logic [31:0] info_word(input int unsigned num_pads,
                                              input int unsigned num_funcs);
        return 32'((num_funcs << InfoNumFuncsLsb) | (num_pads << InfoNumPadsLsb));
    endfunction

endpackage

// File: rtl/cheshire_pad_mux_slice.sv
// One pad of the multiplexer: input synchronizer, function select register,
// registered output path and a one-cycle output-enable gap on select changes.
module cheshire_pad_mux_slice
    import cheshire_pad_mux_pkg::*;
#(
    parameter int unsigned NumFuncs   = 4,
    parameter int unsigned SyncStages = 2,
    localparam int unsigned FuncW     = $clog2(NumFuncs)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  pad_cfg_t            cfg_i,
    input  logic                pad_in_i,
    input  logic [NumFuncs-1:0] func_out_i,
    input  logic [NumFuncs-1:0] func_oe_i,
    output logic                pad_out_o,
    output logic                pad_oe_o,
    output logic [NumFuncs-1:0] func_in_o,
    output logic [FuncW-1:0]    sel_o
);

    logic [SyncStages-1:0] sync_q;
    logic [FuncW-1:0]      sel_q;
    logic                  out_q;
    logic                  oe_q;
    logic                  bbm_q;
    logic                  sel_changed;

    // Full-width compare so a same-value rewrite never opens a gap.
    assign sel_changed = cfg_i.we && (MaxFuncW'(sel_q) != cfg_i.sel);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
            sel_q  <= '0;
            out_q  <= 1'b0;
            oe_q   <= 1'b0;
            bbm_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SyncStages-2:0], pad_in_i};
            if (cfg_i.we) begin
                sel_q <= cfg_i.sel[FuncW-1:0];
            end
            out_q <= func_out_i[sel_q];
            oe_q  <= func_oe_i[sel_q];
            bbm_q <= sel_changed;
        end
    end

    // The old function's enable is masked during the cycle the new one is being registered.
    assign pad_out_o = out_q;
    assign pad_oe_o  = oe_q & ~bbm_q;
    assign sel_o     = sel_q;

    always_comb begin
        func_in_o = '0;
        for (int unsigned f = 0; f < NumFuncs; f++) begin
            func_in_o[f] = sync_q[SyncStages-1] && (sel_q == FuncW'(f));
        end
    end

endmodule

// File: rtl/cheshire_pad_mux.sv
// Pad multiplexer top: word-addressed config port (SEL per pad, sticky LOCK,
// read-only INFO) driving NumPads per-pad slices.
module cheshire_pad_mux
    import cheshire_pad_mux_pkg::*;
#(
    parameter int unsigned NumPads    = 32,
    parameter int unsigned NumFuncs   = 4,
    parameter int unsigned SyncStages = 2,
    parameter int unsigned AddrWidth  = 8
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              cfg_req_valid_i,
    input  logic                              cfg_req_write_i,
    input  logic [AddrWidth-1:0]              cfg_req_addr_i,
    input  logic [31:0]                       cfg_req_wdata_i,
    output logic                              cfg_req_ready_o,
    output logic                              cfg_rsp_valid_o,
    output logic [31:0]                       cfg_rsp_rdata_o,
    output logic                              cfg_rsp_error_o,
    input  logic [NumPads-1:0]                pad_in_i,
    output logic [NumPads-1:0]                pad_out_o,
    output logic [NumPads-1:0]                pad_oe_o,
    input  logic [NumFuncs-1:0][NumPads-1:0]  func_out_i,
    input  logic [NumFuncs-1:0][NumPads-1:0]  func_oe_i,
    output logic [NumFuncs-1:0][NumPads-1:0]  func_in_o
);

    localparam int unsigned FuncW    = $clog2(NumFuncs);
    localparam int unsigned LockWord = NumPads + LockWordOffset;
    localparam int unsigned InfoWord = NumPads + InfoWordOffset;

    logic [31:0] word_idx;
    reg_kind_e   req_kind;
    logic        accept;
    logic        req_err;
    logic        sel_write;
    logic [31:0] req_rdata;
    logic [31:0] sel_rdata;

    logic        rsp_valid_q;
    logic        rsp_error_q;
    logic [31:0] rsp_rdata_q;
    logic        lock_q;

    pad_cfg_t            pad_cfg  [NumPads];
    logic [FuncW-1:0]    pad_sel  [NumPads];
    logic [NumFuncs-1:0] pad_fout [NumPads];
    logic [NumFuncs-1:0] pad_foe  [NumPads];
    logic [NumFuncs-1:0] pad_fin  [NumPads];

    assign word_idx        = 32'(cfg_req_addr_i[AddrWidth-1:2]);
    assign cfg_req_ready_o = ~rsp_valid_q;
    assign accept          = cfg_req_valid_i & cfg_req_ready_o;

    always_comb begin
        req_kind = RegNone;
        if (word_idx < NumPads) begin
            req_kind = RegSel;
        end else if (word_idx == LockWord) begin
            req_kind = RegLock;
        end else if (word_idx == InfoWord) begin
            req_kind = RegInfo;
        end
    end

    always_comb begin
        sel_rdata = '0;
        for (int unsigned p = 0; p < NumPads; p++) begin
            if (word_idx == p) begin
                sel_rdata = 32'(pad_sel[p]);
            end
        end
    end

    always_comb begin
        req_err = 1'b0;
        if (cfg_req_addr_i[1:0] != 2'b00 || req_kind == RegNone) begin
            req_err = 1'b1;
        end else if (cfg_req_write_i) begin
            case (req_kind)
                RegSel:  req_err = lock_q | (cfg_req_wdata_i >= 32'(NumFuncs));
                RegLock: req_err = lock_q;
                default: req_err = 1'b1;
            endcase
        end
    end

    always_comb begin
        req_rdata = '0;
        if (!cfg_req_write_i && !req_err) begin
            case (req_kind)
                RegSel:  req_rdata = sel_rdata;
                RegLock: req_rdata = {31'b0, lock_q};
                RegInfo: req_rdata = info_word(NumPads, NumFuncs);
                default: req_rdata = '0;
            endcase
        end
    end

    assign sel_write = accept & cfg_req_write_i & ~req_err & (req_kind == RegSel);

    // Response fields are cleared outside the strobe cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            rsp_rdata_q <= '0;
            lock_q      <= 1'b0;
        end else begin
            rsp_valid_q <= accept;
            rsp_error_q <= accept & req_err;
            rsp_rdata_q <= accept ? req_rdata : '0;
            if (accept && cfg_req_write_i && !req_err && req_kind == RegLock &&
                cfg_req_wdata_i[0]) begin
                lock_q <= 1'b1;
            end
        end
    end

    assign cfg_rsp_valid_o = rsp_valid_q;
    assign cfg_rsp_error_o = rsp_error_q;
    assign cfg_rsp_rdata_o = rsp_rdata_q;

    for (genvar p = 0; p < NumPads; p++) begin : g_pad
        assign pad_cfg[p].we  = sel_write && (word_idx == 32'(p));
        assign pad_cfg[p].sel = cfg_req_wdata_i[MaxFuncW-1:0];

        for (genvar f = 0; f < NumFuncs; f++) begin : g_func
            assign pad_fout[p][f] = func_out_i[f][p];
            assign pad_foe[p][f]  = func_oe_i[f][p];
            assign func_in_o[f][p] = pad_fin[p][f];
        end

        cheshire_pad_mux_slice #(
            .NumFuncs   (NumFuncs),
            .SyncStages (SyncStages)
        ) u_slice (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .cfg_i      (pad_cfg[p]),
            .pad_in_i   (pad_in_i[p]),
            .func_out_i (pad_fout[p]),
            .func_oe_i  (pad_foe[p]),
            .pad_out_o  (pad_out_o[p]),
            .pad_oe_o   (pad_oe_o[p]),
            .func_in_o  (pad_fin[p]),
            .sel_o      (pad_sel[p])
        );
    end

endmodule

// File: doc/cheshire_pad_mux.md
CHESHIRE_PAD_MUX -- requirements
Module: cheshire_pad_mux

Interface
REQ-001 SHALL have parameter NumPads, default 32: number of chip pads muxed (1..64).
REQ-002 SHALL have parameter NumFuncs, default 4: alternate functions per pad (2..16), FuncW = $clog2(NumFuncs).
REQ-003 SHALL have parameter SyncStages, default 2: input synchronizer depth (>=2).
REQ-004 SHALL have parameter AddrWidth, default 8: config-port byte address width.
REQ-005 SHALL have ports:
  clk_i  in  1  sole clock;
  rst_i  in  1  asynchronous, active-high reset;
  cfg_req_valid_i  in  1  config request;
  cfg_req_write_i  in  1  1=write, 0=read;
  cfg_req_addr_i  in  AddrWidth  byte address;
  cfg_req_wdata_i  in  32  write data;
  cfg_req_ready_o  out  1  request accepted;
  cfg_rsp_valid_o  out  1  response strobe;
  cfg_rsp_rdata_o  out  32  read data;
  cfg_rsp_error_o  out  1  access error;
  pad_in_i  in  NumPads  raw pad inputs;
  pad_out_o  out  NumPads  pad output data;
  pad_oe_o  out  NumPads  pad output enable;
  func_out_i  in  NumFuncs x NumPads  per-function output data;
  func_oe_i  in  NumFuncs x NumPads  per-function output enable;
  func_in_o  out  NumFuncs x NumPads  per-function synchronized inputs.

Function
REQ-006 SHALL hold per pad a SEL register (FuncW bits) at word index p (0..NumPads-1), bits [FuncW-1:0].
REQ-007 SHALL hold a LOCK register (bit 0) at word index NumPads; INFO (read-only: [7:0]=NumPads, [15:8]=NumFuncs) at NumPads+1.
REQ-008 SHALL assert cfg_req_ready_o whenever no response is pending; request accepted on valid&ready.
REQ-009 SHALL return cfg_rsp_valid_o exactly one cycle after acceptance, high for one cycle; rdata zero-extended, 0 on writes and errors.
REQ-010 SHALL flag error (no state change) for: addr[1:0]!=0, word index >NumPads+1, write to INFO, write to SEL/LOCK while locked, SEL write data >=NumFuncs.
REQ-011 SHALL make LOCK sticky: once 1, only reset clears it.
REQ-012 SHALL register pad outputs: pad_out_o[p], pad_oe_o[p] reflect func_out_i/func_oe_i[SEL[p]][p] one cycle later.
REQ-013 SHALL, when a write changes SEL[p] to a different value, force pad_oe_o[p]=0 for exactly one cycle after the update (break-before-make); same-value write causes no gap.
REQ-014 SHALL synchronize pad_in_i through SyncStages flops; func_in_o[f][p] = synced pad_in[p] if SEL[p]==f, else 0.
REQ-015 SHALL update SEL at the clock edge that accepts the write; pad_in latency to func_in_o is SyncStages cycles.

Reset
REQ-016 SHALL on rst_i asynchronously clear all SEL, LOCK, sync flops, break-before-make flags; pad_out_o=0, pad_oe_o=0, cfg_rsp_valid_o=0, cfg_rsp_error_o=0, cfg_rsp_rdata_o=0, func_in_o=0.
REQ-017 SHALL drop any in-flight response on reset mid-transaction; cfg_req_ready_o=1 after release.

Structure
REQ-018 SHALL place register word-index constants, INFO field positions and pad-config struct in cheshire_pad_mux_pkg.
REQ-019 SHALL implement one sub-module cheshire_pad_mux_slice (per-pad sync, select, output register, break-before-make), generated NumPads times.

Verification
REQ-020 SHALL cover: reset, then read INFO (addr 0x84) -> rdata 0x0000_0420, error 0.
REQ-021 SHALL cover: write SEL[3]=2 (addr 0x0C), func_oe_i[2][3]=1 -> pad_oe_o[3]=0 one cycle after update, then 1; pad_out_o[3] tracks func_out_i[2][3].
REQ-022 SHALL cover: write SEL[5]=4 -> error 1, SEL[5] stays 0; write addr 0x0E -> error 1.
REQ-023 SHALL cover: write LOCK=1 (addr 0x80), then write SEL[0]=1 -> error 1, SEL[0] reads 0; LOCK reads 1.
REQ-024 SHALL cover: SEL[7]=1, pulse pad_in_i[7] -> func_in_o[1][7] rises after 2 cycles, func_in_o[0][7] stays 0.
REQ-025 SHALL cover: rst_i asserted during pending response -> cfg_rsp_valid_o never fires, all SEL/LOCK read 0 afterwards.
